aes128_round_sequencer: RTL and testbench
=========================================

# aes128_round_sequencer

Iterative AES-128 encryption controller. It accepts one plaintext/key pair per valid/ready handshake and performs the round-0 AddRoundKey. It then sequences a shared combinational round datapath (`aes_round_datapath`, instantiated by the parent) through 10 rounds, one round per cycle, generating RCON as it goes. The ciphertext is returned on a valid/ready output port. The sequencer replaces ten unrolled key-expansion stages with a single reused key-step/round path.

## Interface
- `NR`, 10: number of rounds. Only 10 is supported (AES-128).
- `RCON_INIT`, 8'h01: RCON value used for round 1.

- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  plaintext/key offered.
- `in_ready`  out  1  sequencer can accept.
- `in_plaintext`  in  128  plaintext block, byte 0 = bits [127:120].
- `in_key`  in  128  cipher key, same byte order.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer takes ciphertext.
- `out_ciphertext`  out  128  result, held while `out_valid`.
- `rd_state`  out  128  current state to datapath.
- `rd_key`  out  128  previous round key to datapath key step.
- `rd_rcon`  out  8  RCON for current key step.
- `rd_final`  out  1  final round: datapath skips MixColumns.
- `rd_next_state`  in  128  datapath result for the round, using `rd_next_key`.
- `rd_next_key`  in  128  expanded round key.
- `busy`  out  1  high in ROUND.
- `round`  out  4  current round number, 0 when idle.

## Operation
- States are IDLE, ROUND and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: `state_q`<=`in_plaintext`^`in_key`; `key_q`<=`in_key`; `rcon_q`<=`RCON_INIT`; `round`<=1; go to ROUND.
- **ROUND**
  - Drive `rd_state`=`state_q`, `rd_key`=`key_q`, `rd_rcon`=`rcon_q`, `rd_final`=(`round`==NR).
  - Every cycle: `state_q`<=`rd_next_state`; `key_q`<=`rd_next_key`; `rcon_q`<=xtime(`rcon_q`); `round`<=`round`+1.
  - When `round`==NR: go to DONE and set `round`<=0.
- **DONE**
  - `out_valid`=1; `out_ciphertext`=`state_q`.
  - On `out_ready` alone: go to IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`), gated low while `reset`=0.
- Simultaneous output handshake and `in_valid` in DONE: the new block loads as in IDLE and the FSM goes directly to ROUND.
- xtime(r) = {r[6:0],0} ^ (r[7] ? 8'h1B : 0). Sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Inputs are sampled only at the accept edge. `in_plaintext`/`in_key` changes afterwards are ignored.
- `rd_*` outputs are don't-care outside ROUND but must equal the register contents (no X).
- `rd_final` is never high outside round 10.

## Timing
- **Reset** (`reset`=0 at an edge): state=IDLE; `state_q`, `key_q`, `round` cleared; `rcon_q`=`RCON_INIT`.
  - Outputs: `out_valid`=0, `out_ciphertext`=0, `busy`=0, `round`=0, `in_ready`=0 while reset is low, `rd_final`=0.
  - Reset mid-ROUND or mid-DONE aborts the block. No output is produced.
- **Latency:** accept at edge T. Rounds 1..10 are captured at edges T+1..T+10. `out_valid` is high from edge T+10, i.e. 10 cycles after accept.
- **Throughput:** 11 cycles per block with the DONE/accept overlap, 12 without.
- **Output handshake:** `out_valid` does not drop and `out_ciphertext` does not change until `out_valid`&`out_ready`.
- The datapath is purely combinational. `rd_next_*` must settle within one cycle of `rd_*`.

## Structure
- Shared package `aes_pkg`:
  - `AES_NR`=10, `AES_RCON_INIT`=8'h01.
  - The `xtime` function.
  - State enum {IDLE, ROUND, DONE}.
  - 128-bit block typedef.
- No sub-module inside the sequencer. RCON is generated inline with the package function. `aes_round_datapath` (SubBytes, ShiftRows, MixColumns, AddRoundKey plus the key step) is a sibling instantiated by the parent.

## Test plan
- **FIPS-197 App. B** (bench uses reference datapath model): pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, `out_ready`=1 → `out_valid` 10 cycles after accept, ct 3925841d02dc09fbdc118597196a0b32.
- **FIPS-197 App. C.1:** pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → ct 69c4e0d86a7b0430d8cdb78070b4c55a. Check that `rd_rcon` per round reads 01,02,04,08,10,20,40,80,1B,36 and `rd_final` is high only at round 10.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` → `out_valid` stays 1, ct stable, `in_ready`=0. Assert `out_ready` → handshake, then IDLE.
- **Back-to-back:** B-vector followed immediately by C.1 with `in_valid` held → second accept coincides with the first output handshake, second ct appears 11 cycles after the first, both correct.
- **Reset mid-op:** drive `reset`=0 for one cycle at round 5 → next cycle `busy`=0, `round`=0, `out_valid`=0. A fresh C.1 run afterwards still produces the correct ct.
- **Input change after accept:** change `in_plaintext`/`in_key` during ROUND → result unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_pkg : shared AES-128 constants, FSM states, block type and xtime     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package aes_pkg;

  localparam int         AES_NR        = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_round_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes128_round_sequencer : iterative AES-128 controller driving a shared   |
// | combinational round/key-step datapath. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module aes128_round_sequencer
  import aes_pkg::*;
#(
  parameter int         NR        = AES_NR,
  parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_plaintext,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ciphertext,
  output logic [127:0] rd_state,
  output logic [127:0] rd_key,
  output logic [7:0]   rd_rcon,
  output logic         rd_final,
  input  logic [127:0] rd_next_state,
  input  logic [127:0] rd_next_key,
  output logic         busy,
  output logic [3:0]   round
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_state_e fsm_q, fsm_d;
  aes_block_t state_q, state_d;
  aes_block_t key_q, key_d;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] round_q, round_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       accept;

  // DONE may hand off and accept in the same cycle, saving one cycle per block.
  assign in_ready = reset & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    key_d    = key_q;
    rcon_d   = rcon_q;
    round_d  = round_q;
    case (fsm_q)
      IDLE: ;
      ROUND: begin
        state_d = rd_next_state;
        key_d   = rd_next_key;
        rcon_d  = xtime(rcon_q);
        if (round_q == LAST_ROUND) begin
          fsm_d   = DONE;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    if (accept) begin
      fsm_d   = ROUND;
      state_d = in_plaintext ^ in_key;
      key_d   = in_key;
      rcon_d  = RCON_INIT;
      round_d = 4'd1;
    end
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d == ROUND);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rcon_q      <= RCON_INIT;
      round_q     <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_state       = state_q;
  assign rd_key         = key_q;
  assign rd_rcon        = rcon_q;
  assign rd_final       = busy_q & (round_q == LAST_ROUND);
  assign out_valid      = out_valid_q;
  assign out_ciphertext = out_valid_q ? state_q : '0;
  assign busy           = busy_q;
  assign round          = round_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes128_round_sequencer : sequencer bench with behavioural AES round   |
// | datapath and full-cipher reference model. Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module tb_aes128_round_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_plaintext = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ciphertext;
  logic [127:0] rd_state, rd_key, rd_next_state, rd_next_key;
  logic [7:0]   rd_rcon;
  logic         rd_final;
  logic         busy;
  logic [3:0]   round;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
  logic [127:0] key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [127:0] pt_c1  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [7:0]   rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_round_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_plaintext(in_plaintext), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ciphertext(out_ciphertext),
    .rd_state(rd_state), .rd_key(rd_key), .rd_rcon(rd_rcon), .rd_final(rd_final),
    .rd_next_state(rd_next_state), .rd_next_key(rd_next_key),
    .busy(busy), .round(round)
  );

  // ---------------- behavioural AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01; s = x;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [127:0] t;
    t = sub_shift(s);
    if (!fin) t = mix_columns(t);
    return t ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    logic [7:0] rc;
    s = pt ^ key; k = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k  = key_step(k, rc);
      s  = enc_round(s, k, r == 10);
      rc = gmul(rc, 8'h02);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference datapath sitting beside the sequencer.
  assign rd_next_key   = key_step(rd_key, rd_rcon);
  assign rd_next_state = enc_round(rd_state, rd_next_key, rd_final);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    in_plaintext = pt; in_key = key; in_valid = 1'b1;
    for (int n = 0; n < 40 && !in_ready; n++) step();
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    checks++;
    if ({out_valid, busy, rd_final, in_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got v/b/f/r=%b required 0000", {out_valid, busy, rd_final, in_ready});
    end
    checks++;
    if (round !== 4'd0 || out_ciphertext !== '0) begin
      errors++; $display("FAIL reset_values round=%0d ct=%h required 0 and 0", round, out_ciphertext);
    end
    reset = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready=%b required 1", in_ready); end
    step();
  endtask

  task automatic test_kat_b();
    int n;
    out_ready = 1'b1;
    send(pt_b, key_b);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL kat_b_latency got %0d required 10", n); end
    checks++;
    if (out_ciphertext !== ct_b) begin errors++; $display("FAIL kat_b_ct got %h required %h", out_ciphertext, ct_b); end
    checks++;
    if (busy !== 1'b0 || round !== 4'd0) begin errors++; $display("FAIL kat_b_done busy=%b round=%0d required 0 0", busy, round); end
    step();
  endtask

  task automatic test_kat_c1();
    out_ready = 1'b1;
    send(pt_c1, key_c1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rd_rcon !== rcon_tbl[i] || round !== 4'(i + 1) || busy !== 1'b1) begin
        errors++; $display("FAIL c1_round%0d rcon=%h round=%0d busy=%b required %h %0d 1", i + 1, rd_rcon, round, busy, rcon_tbl[i], i + 1);
      end
      checks++;
      if (rd_final !== (i == 9)) begin errors++; $display("FAIL c1_final%0d got %b required %b", i + 1, rd_final, i == 9); end
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_ciphertext !== ct_c1) begin
      errors++; $display("FAIL c1_ct valid=%b got %h required 1 %h", out_valid, out_ciphertext, ct_c1);
    end
    checks++;
    if (rd_final !== 1'b0) begin errors++; $display("FAIL c1_final_done got %b required 0", rd_final); end
    step();
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, key, exp_ct, held;
    int n;
    pt = rand128(); key = rand128(); exp_ct = aes_encrypt(pt, key);
    out_ready = 1'b0;
    send(pt, key);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++;
    if (out_ciphertext !== exp_ct) begin errors++; $display("FAIL bp_ct got %h required %h", out_ciphertext, exp_ct); end
    held = out_ciphertext;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ciphertext !== held || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d v=%b ct=%h rdy=%b required 1 %h 0", i, out_valid, out_ciphertext, in_ready, held);
      end
    end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b required 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_idle v=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    out_ready = 1'b1;
    in_plaintext = pt_b; in_key = key_b; in_valid = 1'b1;
    for (int k = 0; k < 40 && !in_ready; k++) step();
    step();
    in_plaintext = pt_c1; in_key = key_c1;
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    t1 = cyc;
    checks++;
    if (out_ciphertext !== ct_b) begin errors++; $display("FAIL b2b_first_ct got %h required %h", out_ciphertext, ct_b); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_overlap_ready got %b required 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || round !== 4'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept busy=%b round=%0d v=%b required 1 1 0", busy, round, out_valid);
    end
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    t2 = cyc;
    checks++;
    if (t2 - t1 !== 11) begin errors++; $display("FAIL b2b_spacing got %0d required 11", t2 - t1); end
    checks++;
    if (out_ciphertext !== ct_c1) begin errors++; $display("FAIL b2b_second_ct got %h required %h", out_ciphertext, ct_c1); end
    step();
  endtask

  task automatic test_reset_mid();
    int n, seen;
    out_ready = 1'b1;
    send(pt_c1, key_c1);
    repeat (4) step();
    checks++;
    if (round !== 4'd5) begin errors++; $display("FAIL rmid_round got %0d required 5", round); end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || round !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_abort busy=%b round=%0d v=%b rdy=%b required 0 0 0 0", busy, round, out_valid, in_ready);
    end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rmid_no_output got %0d valid cycles required 0", seen); end
    send(pt_c1, key_c1);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++;
    if (out_ciphertext !== ct_c1 || n !== 10) begin
      errors++; $display("FAIL rmid_rerun ct=%h lat=%0d required %h 10", out_ciphertext, n, ct_c1);
    end
    step();
  endtask

  task automatic test_input_change();
    logic [127:0] pt, key, exp_ct;
    int n;
    pt = rand128(); key = rand128(); exp_ct = aes_encrypt(pt, key);
    out_ready = 1'b1;
    send(pt, key);
    n = 0;
    while (!out_valid && n < 30) begin
      in_plaintext = rand128(); in_key = rand128();
      step(); n++;
    end
    checks++;
    if (out_ciphertext !== exp_ct) begin errors++; $display("FAIL inchg_ct got %h required %h", out_ciphertext, exp_ct); end
    step();
  endtask

  task automatic test_random();
    logic [127:0] pt, key, exp_ct;
    int n, d;
    for (int b = 0; b < 6; b++) begin
      pt = rand128(); key = rand128(); exp_ct = aes_encrypt(pt, key);
      d = $urandom_range(0, 3);
      out_ready = 1'b0;
      send(pt, key);
      n = 0;
      while (!out_valid && n < 30) begin step(); n++; end
      checks++;
      if (n !== 10 || out_ciphertext !== exp_ct) begin
        errors++; $display("FAIL rand%0d lat=%0d ct=%h required 10 %h", b, n, out_ciphertext, exp_ct);
      end
      repeat (d) step();
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_release v=%b required 0", b, out_valid); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_kat_b();
    test_kat_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
